// File: rtl/reg_wb_buffer.sv
// Two-entry in-order write-back buffer feeding four load registers via one-hot strobes.
// Define WB_BYPASS_EN to forward a result straight to ld/d when the buffer is empty.
module reg_wb_buffer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              hold,
  output logic [3:0]        ld,
  output logic [DATA_W-1:0] d,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [1:0]        dest_q [2];
  logic [1:0]        dest_d [2];
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;

  logic push;
  logic pop;
  logic bypass;
  logic tail;

  always_comb begin
    in_ready = rst_n && (count_q != 2'd2);
    pop      = (count_q != 2'd0) && !hold;
`ifdef WB_BYPASS_EN
    // Empty buffer and no stall: forward the result instead of storing it.
    bypass   = in_valid && in_ready && (count_q == 2'd0) && !hold;
`else
    bypass   = 1'b0;
`endif
    push     = in_valid && in_ready && !bypass;
    // Slot after the last valid entry; count is 0 or 1 whenever a push is allowed.
    tail     = head_q ^ count_q[0];
  end

  always_comb begin
    data_d  = data_q;
    dest_d  = dest_q;
    head_d  = head_q;
    count_d = count_q;
    if (push) begin
      data_d[tail] = in_data;
      dest_d[tail] = in_dest;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      dest_q[0] <= '0;
      dest_q[1] <= '0;
      head_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      data_q    <= data_d;
      dest_q    <= dest_d;
      head_q    <= head_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    ld = 4'b0000;
    d  = '0;
    if (count_q != 2'd0) begin
      d = data_q[head_q];
    end
    if (pop) begin
      ld[dest_q[head_q]] = 1'b1;
    end
    if (bypass) begin
      ld[in_dest] = 1'b1;
      d           = in_data;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Scoreboard bench for reg_wb_buffer: accepted results are queued and matched against ld/d.
module tb_reg_wb_buffer;

`ifdef WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  dest;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_dest;
  logic        hold;
  logic [3:0]  ld;
  logic [15:0] d;
  logic [1:0]  count;

  int   n_checks = 0;
  int   n_fails  = 0;
  ent_t sb_q [$];

  reg_wb_buffer #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .hold     (hold),
    .ld       (ld),
    .d        (d),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      int   sz;
      bit   byp;
      bit   drain;
      ent_t e;
      sz  = sb_q.size();
      check_eq("count", {30'd0, count}, sz);
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
      byp = Byp && in_valid && (sz == 0) && !hold;
      if (in_valid && sz < 2) sb_q.push_back({in_dest, in_data});
      drain = !hold && (sz > 0 || byp);
      if (drain) begin
        e = sb_q.pop_front();
        check_eq("ld_drain", {28'd0, ld}, {28'd0, 4'b0001 << e.dest});
        check_eq("d_drain", {16'd0, d}, {16'd0, e.data});
      end else begin
        check_eq("ld_idle", {28'd0, ld}, 32'd0);
        check_eq("d_idle", {16'd0, d}, (sz > 0) ? {16'd0, sb_q[0].data} : 32'd0);
      end
    end
  end

  task automatic push_one(input logic [1:0] dst, input logic [15:0] dat);
    in_valid = 1'b1;
    in_dest  = dst;
    in_data  = dat;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    hold     = 1'b0;

    // Reset for two cycles
    cycle();
    check_eq("rdy_in_rst", {31'd0, in_ready}, 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    check_eq("rst_count", {30'd0, count}, 32'd0);
    check_eq("rst_ld", {28'd0, ld}, 32'd0);
    check_eq("rst_d", {16'd0, d}, 32'd0);
    check_eq("rst_rdy", {31'd0, in_ready}, 32'd1);

    // Single push, one-cycle latency (zero with bypass)
    push_one(2'd2, 16'hBEEF);
    cycle();
    in_valid = 1'b0;
    check_eq("beef_ld", {28'd0, ld}, Byp ? 32'd0 : 32'h4);
    check_eq("beef_d", {16'd0, d}, Byp ? 32'd0 : 32'hBEEF);
    cycle();
    check_eq("beef_cnt", {30'd0, count}, 32'd0);
    check_eq("beef_ld0", {28'd0, ld}, 32'd0);

    // Bypass probe
    push_one(2'd1, 16'hA5A5);
    #1;
    check_eq("a5_ld_now", {28'd0, ld}, Byp ? 32'h2 : 32'd0);
    check_eq("a5_d_now", {16'd0, d}, Byp ? 32'hA5A5 : 32'd0);
    cycle();
    in_valid = 1'b0;
    check_eq("a5_ld_next", {28'd0, ld}, Byp ? 32'd0 : 32'h2);
    check_eq("a5_cnt", {30'd0, count}, Byp ? 32'd0 : 32'd1);
    cycle();

    // Fill under hold, overflow attempt, then release
    hold = 1'b1;
    push_one(2'd0, 16'h1111);
    cycle();
    push_one(2'd3, 16'h2222);
    cycle();
    push_one(2'd1, 16'h3333);
    #1;
    check_eq("full_cnt", {30'd0, count}, 32'd2);
    check_eq("full_rdy", {31'd0, in_ready}, 32'd0);
    cycle();
    cycle();
    in_valid = 1'b0;
    hold     = 1'b0;
    #1;
    check_eq("rel_ld0", {28'd0, ld}, 32'h1);
    check_eq("rel_d0", {16'd0, d}, 32'h1111);
    cycle();
    check_eq("rel_ld1", {28'd0, ld}, 32'h8);
    check_eq("rel_d1", {16'd0, d}, 32'h2222);
    cycle();
    check_eq("rel_ld2", {28'd0, ld}, 32'd0);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      push_one(2'(i), 16'h5000 + 16'(i));
      cycle();
      if (i >= 1) check_eq("stream_cnt", {30'd0, count}, Byp ? 32'd0 : 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Reset with two entries buffered
    hold = 1'b1;
    push_one(2'd1, 16'h7777);
    cycle();
    push_one(2'd2, 16'h8888);
    cycle();
    in_valid = 1'b0;
    check_eq("pre_rst_cnt", {30'd0, count}, 32'd2);
    rst_n = 1'b0;
    sb_q.delete();
    cycle();
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_cnt", {30'd0, count}, 32'd0);
    check_eq("mid_rst_ld", {28'd0, ld}, 32'd0);
    check_eq("mid_rst_d", {16'd0, d}, 32'd0);
    hold = 1'b0;
    cycle();
    check_eq("post_rst_ld", {28'd0, ld}, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 3) == 0);
      in_data  = 16'($urandom);
      in_dest  = 2'($urandom_range(0, 3));
      cycle();
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    repeat (4) cycle();
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
